// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and sizing helper for the digit-serial BCD adder.
package bcd_pkg;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit adder still needs a 1-bit counter.
    function automatic int cnt_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit decimal adder; non-BCD digits are summed by the same rule and flagged.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             ci,
    output logic [BCD_W-1:0] digit,
    output logic             co,
    output logic             invalid
);

    logic [4:0] s;
    logic [4:0] s_adj;

    always_comb begin
        s       = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        s_adj   = s - 5'd10;
        digit   = s[3:0];
        co      = 1'b0;
        if (s >= 5'd10) begin
            digit = s_adj[3:0];
            co    = 1'b1;
        end
        invalid = (x > 4'(BCD_MAX)) || (y > 4'(BCD_MAX));
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, one digit per clock, LSD first, with start/busy/done handshake.
// Optional sticky non-BCD input flag 'err' is built when BCD_ERR_CHECK_EN is defined.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] sum,
    output logic                    cout
`ifdef BCD_ERR_CHECK_EN
    ,
    output logic                    err
`endif
);

    localparam int W  = BCD_W * DIGITS;
    localparam int CW = cnt_width(DIGITS);

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   work;
    logic [W-1:0]   work_next;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic [BCD_W-1:0] digit;
    logic           digit_co;
    logic           digit_invalid;
    logic           accept;
    logic           last;

    bcd_digit_add u_digit_add (
        .x       (op_a[BCD_W-1:0]),
        .y       (op_b[BCD_W-1:0]),
        .ci      (carry),
        .digit   (digit),
        .co      (digit_co),
        .invalid (digit_invalid)
    );

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CW'(DIGITS - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // New digits enter the work register from the top so the LSD ends up at the bottom.
    generate
        if (DIGITS == 1) begin : g_one
            assign work_next = digit;
        end else begin : g_many
            assign work_next = {digit, work[W-1:BCD_W]};
        end
    endgenerate

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_a  <= a;
                op_b  <= b;
                carry <= cin;
                cnt   <= '0;
                work  <= '0;
            end else if (state == RUN) begin
                op_a  <= op_a >> BCD_W;
                op_b  <= op_b >> BCD_W;
                carry <= digit_co;
                cnt   <= cnt + 1'b1;
                work  <= work_next;
                if (last) begin
                    sum  <= work_next;
                    cout <= digit_co;
                end
            end
        end
    end

`ifdef BCD_ERR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if ((state == RUN) && digit_invalid) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_invalid;
    assign unused_invalid = digit_invalid;
`endif

endmodule
